// File: rtl/cam_pkg.sv
// Shared types and default geometry for the camera frame-capture path.
package cam_pkg;

  localparam int DEF_COL_PIXELS = 320;
  localparam int DEF_ROW_PIXELS = 240;
  localparam int DEF_NUM_PIXELS = 76800;
  localparam int ADDR_W         = 17;

  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SOF,
    CAPTURE,
    DONE
  } state_t;

endpackage

// File: rtl/cam_input_sync.sv
// Brings the camera bus into the clk domain and flags each pixel-clock rise.
module cam_input_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic       cam_pclk,
  input  logic       cam_vsync,
  input  logic       cam_href,
  input  logic [7:0] cam_data,
  output logic       pclk_rise,
  output logic       vsync_s,
  output logic       href_s,
  output logic [7:0] data_s
);

  // All camera lines share one chain so they stay mutually aligned.
  logic [10:0] meta_reg;
  logic [10:0] sync_reg;
  logic        pclk_prev_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_reg      <= '0;
      sync_reg      <= '0;
      pclk_prev_reg <= 1'b0;
    end else begin
      meta_reg      <= {cam_pclk, cam_vsync, cam_href, cam_data};
      sync_reg      <= meta_reg;
      pclk_prev_reg <= sync_reg[10];
    end
  end

  assign pclk_rise = sync_reg[10] & ~pclk_prev_reg;
  assign vsync_s   = sync_reg[9];
  assign href_s    = sync_reg[8];
  assign data_s    = sync_reg[7:0];

endmodule

// File: rtl/frame_capture_ctrl.sv
// Captures one RGB444 camera frame per request into a frame buffer and reports
// whether the line and pixel counts matched the expected geometry.
module frame_capture_ctrl
  import cam_pkg::*;
#(
  parameter int COL_PIXELS = DEF_COL_PIXELS,
  parameter int ROW_PIXELS = DEF_ROW_PIXELS,
  parameter int NUM_PIXELS = DEF_NUM_PIXELS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cam_pclk,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  input  logic        capture_req,
  output logic        wr_en,
  output addr_t       wr_addr,
  output logic [11:0] wr_data,
  output logic        frame_valid,
  output logic        frame_error
);

  // Never write past the physical buffer even if the parameters disagree.
  localparam int PIX_LIMIT = (NUM_PIXELS < COL_PIXELS * ROW_PIXELS) ?
                             NUM_PIXELS : COL_PIXELS * ROW_PIXELS;

  logic        pclk_rise;
  logic        vsync_s;
  logic        href_s;
  logic [7:0]  data_s;

  state_t      state_reg, state_next;
  logic        vsync_prev_reg, href_prev_reg;
  logic        phase_reg;
  logic [3:0]  red_reg;
  addr_t       pix_cnt_reg;
  logic [15:0] line_cnt_reg;
  logic        wr_en_reg;
  addr_t       wr_addr_reg;
  logic [11:0] wr_data_reg;
  logic        frame_error_reg;

  logic        vs_fall, vs_rise, href_fall, in_capture, pix_write;
  addr_t       pix_cnt_after;
  logic [15:0] line_cnt_after;

  cam_input_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .cam_pclk  (cam_pclk),
    .cam_vsync (cam_vsync),
    .cam_href  (cam_href),
    .cam_data  (cam_data),
    .pclk_rise (pclk_rise),
    .vsync_s   (vsync_s),
    .href_s    (href_s),
    .data_s    (data_s)
  );

  assign vs_fall    = pclk_rise & vsync_prev_reg & ~vsync_s;
  assign vs_rise    = pclk_rise & ~vsync_prev_reg & vsync_s;
  assign href_fall  = pclk_rise & href_prev_reg & ~href_s;
  assign in_capture = (state_reg == CAPTURE);
  // Second byte of a pair: href held high since the previous sample, phase 1.
  assign pix_write  = in_capture & pclk_rise & href_s & href_prev_reg & phase_reg &
                      (pix_cnt_reg < addr_t'(PIX_LIMIT));

  // Counts including this cycle's events, so a frame end coinciding with the
  // last write or line end still judges the complete frame.
  assign pix_cnt_after  = pix_cnt_reg + addr_t'(pix_write);
  assign line_cnt_after = line_cnt_reg + 16'(href_fall & in_capture);

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (capture_req) state_next = WAIT_SOF;
      WAIT_SOF: if (vs_fall)     state_next = CAPTURE;
      CAPTURE:  if (vs_rise)     state_next = DONE;
      DONE:     if (capture_req) state_next = WAIT_SOF;
      default:                   state_next = IDLE;
    endcase
  end

  always_comb begin
    frame_valid = (state_reg == DONE);
    frame_error = frame_error_reg;
    wr_en       = wr_en_reg;
    wr_addr     = wr_addr_reg;
    wr_data     = wr_data_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_prev_reg  <= 1'b0;
      href_prev_reg   <= 1'b0;
      phase_reg       <= 1'b0;
      red_reg         <= '0;
      pix_cnt_reg     <= '0;
      line_cnt_reg    <= '0;
      wr_en_reg       <= 1'b0;
      wr_addr_reg     <= '0;
      wr_data_reg     <= '0;
      frame_error_reg <= 1'b0;
    end else begin
      wr_en_reg <= pix_write;
      if (pclk_rise) begin
        vsync_prev_reg <= vsync_s;
        href_prev_reg  <= href_s;
      end

      if (state_reg == WAIT_SOF && state_next == CAPTURE) begin
        pix_cnt_reg  <= '0;
        line_cnt_reg <= '0;
        phase_reg    <= 1'b0;
      end else if (in_capture) begin
        if (pix_write) begin
          wr_addr_reg <= pix_cnt_reg;
          wr_data_reg <= {red_reg, data_s};
        end
        pix_cnt_reg  <= pix_cnt_after;
        line_cnt_reg <= line_cnt_after;
        // A fresh href always starts at phase 0; an unpaired byte is simply overwritten.
        if (pclk_rise && href_s) begin
          if (!href_prev_reg || !phase_reg) begin
            red_reg   <= data_s[3:0];
            phase_reg <= 1'b1;
          end else begin
            phase_reg <= 1'b0;
          end
        end
      end

      if (in_capture && state_next == DONE)
        frame_error_reg <= (pix_cnt_after != addr_t'(NUM_PIXELS)) ||
                           (line_cnt_after != 16'(ROW_PIXELS));
      else if (state_reg == DONE && state_next != DONE)
        frame_error_reg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Randomized frame-capture bench: a frame-level model predicts every buffer write
// and the end-of-frame status; a monitor pops and compares each wr_en pulse.
module tb_frame_capture_ctrl;

  localparam int COLS = 8;
  localparam int ROWS = 6;
  localparam int NUM  = COLS * ROWS;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cam_pclk = 1'b0;
  logic        cam_vsync = 1'b1;
  logic        cam_href = 1'b0;
  logic [7:0]  cam_data = 8'h00;
  logic        capture_req = 1'b0;
  logic        wr_en;
  logic [16:0] wr_addr;
  logic [11:0] wr_data;
  logic        frame_valid;
  logic        frame_error;

  frame_capture_ctrl #(
    .COL_PIXELS (COLS),
    .ROW_PIXELS (ROWS),
    .NUM_PIXELS (NUM)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cam_pclk    (cam_pclk),
    .cam_vsync   (cam_vsync),
    .cam_href    (cam_href),
    .cam_data    (cam_data),
    .capture_req (capture_req),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .frame_valid (frame_valid),
    .frame_error (frame_error)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic [16:0] addr;
    logic [11:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  compared   = 0;
  int  mismatched = 0;

  // Frame-level model of the capture controller.
  bit  m_pending, m_capturing, m_done, m_err;
  int  m_pix, m_lines;
  int  half;

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (wr_en) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_write: got addr=%0d data=%03h, required no write", wr_addr, wr_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (wr_addr !== mon_e.addr || wr_data !== mon_e.data) begin
          mismatched++;
          $display("FAIL write: got addr=%0d data=%03h, required addr=%0d data=%03h",
                   wr_addr, wr_data, mon_e.addr, mon_e.data);
        end else begin
          $display("write addr=%0d data=%03h ok", wr_addr, wr_data);
        end
      end
    end
  end

  task automatic cam_byte(input bit vs, input bit hr, input logic [7:0] d);
    @(negedge clk);
    cam_pclk  = 1'b0;
    cam_vsync = vs;
    cam_href  = hr;
    cam_data  = d;
    repeat (half) @(negedge clk);
    cam_pclk = 1'b1;
    repeat (half - 1) @(negedge clk);
  endtask

  task automatic pulse_req();
    @(negedge clk);
    capture_req = 1'b1;
    @(negedge clk);
    capture_req = 1'b0;
    if (!m_pending && !m_capturing) begin
      m_pending = 1'b1;
      m_done    = 1'b0;
    end
    $display("capture_req issued (pending=%0d)", m_pending);
  endtask

  task automatic end_of_frame_model();
    if (m_capturing) begin
      m_capturing = 1'b0;
      m_done      = 1'b1;
      m_err       = ((m_pix < NUM ? m_pix : NUM) != NUM) || (m_lines != ROWS);
    end
  endtask

  task automatic send_frame(input int lines, input int odd_line, input int req_line,
                            input int rst_pix, input bit vs_on_last, input bit pattern);
    logic [7:0] b, b0;
    int n, nbytes;
    bit last;
    half = $urandom_range(2, 3);
    n = 0;
    b0 = 8'h00;
    repeat (3) cam_byte(1'b1, 1'b0, 8'($urandom));
    cam_byte(1'b0, 1'b0, 8'($urandom));
    if (m_pending) begin
      m_pending   = 1'b0;
      m_capturing = 1'b1;
      m_pix       = 0;
      m_lines     = 0;
    end
    repeat (2) cam_byte(1'b0, 1'b0, 8'($urandom));
    for (int l = 0; l < lines; l++) begin
      if (l == req_line) pulse_req();
      nbytes = 2 * COLS + ((l == odd_line) ? 1 : 0);
      last   = (l == lines - 1) && vs_on_last;
      for (int j = 0; j < nbytes; j++) begin
        if (pattern) b = (j % 2 == 0) ? {4'h0, 4'(n)} : 8'(n);
        else         b = 8'($urandom);
        cam_byte(last && (j == nbytes - 1), 1'b1, b);
        if (j % 2 == 0) begin
          b0 = b;
        end else begin
          if (m_capturing && m_pix < NUM) exp_q.push_back('{17'(m_pix), {b0[3:0], b}});
          if (m_capturing) m_pix++;
          n++;
          if (m_capturing && m_pix == rst_pix) begin
            repeat (8) @(negedge clk);
            rst = 1'b1;
            repeat (2) @(negedge clk);
            rst = 1'b0;
            m_pending = 1'b0; m_capturing = 1'b0; m_done = 1'b0;
            @(negedge clk);
            $display("reset applied at pixel %0d", rst_pix);
            check("rst_wr_en", int'(wr_en), 0);
            check("rst_wr_addr", int'(wr_addr), 0);
            check("rst_wr_data", int'(wr_data), 0);
            check("rst_frame_valid", int'(frame_valid), 0);
            check("rst_frame_error", int'(frame_error), 0);
          end
        end
      end
      if (last) begin
        end_of_frame_model();
      end else begin
        if (m_capturing) m_lines++;
        repeat (2) cam_byte(1'b0, 1'b0, 8'($urandom));
      end
    end
    cam_byte(1'b1, 1'b0, 8'($urandom));
    end_of_frame_model();
    repeat (2) cam_byte(1'b1, 1'b0, 8'($urandom));
    repeat (8) @(negedge clk);
    $display("frame lines=%0d odd=%0d req=%0d rst=%0d vs_last=%0d: valid=%0d err=%0d",
             lines, odd_line, req_line, rst_pix, vs_on_last, frame_valid, frame_error);
    check("frame_valid", int'(frame_valid), int'(m_done));
    if (m_done) check("frame_error", int'(frame_error), int'(m_err));
    check("writes_drained", exp_q.size(), 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lines, odd;
    m_pending = 0; m_capturing = 0; m_done = 0; m_err = 0; m_pix = 0; m_lines = 0;
    half = 2;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_wr_en", int'(wr_en), 0);
    check("reset_wr_addr", int'(wr_addr), 0);
    check("reset_wr_data", int'(wr_data), 0);
    check("reset_frame_valid", int'(frame_valid), 0);
    check("reset_frame_error", int'(frame_error), 0);

    // Nominal frame with an addressable pixel pattern.
    pulse_req();
    send_frame(ROWS, -1, -1, -1, 1'b0, 1'b1);
    // No request: status must hold and nothing is written.
    send_frame(ROWS, -1, -1, -1, 1'b0, 1'b0);
    // Short frame; the second request lands in WAIT_SOF and is ignored.
    pulse_req();
    pulse_req();
    send_frame(ROWS - 1, -1, -1, -1, 1'b0, 1'b0);
    // Odd byte count on one line.
    pulse_req();
    send_frame(ROWS, 2, -1, -1, 1'b0, 1'b0);
    // Too many lines: writes saturate at the last address.
    pulse_req();
    send_frame(ROWS + 1, -1, -1, -1, 1'b0, 1'b0);
    // Request mid-frame: only the following frame is captured.
    send_frame(ROWS, -1, 3, -1, 1'b0, 1'b0);
    send_frame(ROWS, -1, -1, -1, 1'b0, 1'b0);
    // Reset mid-capture, then a clean capture.
    pulse_req();
    send_frame(ROWS, -1, -1, 20, 1'b0, 1'b0);
    pulse_req();
    send_frame(ROWS, -1, -1, -1, 1'b0, 1'b0);
    // vsync rises on the sample that completes the final pixel.
    pulse_req();
    send_frame(ROWS, -1, -1, -1, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      lines = $urandom_range(ROWS - 1, ROWS + 1);
      odd   = ($urandom_range(0, 1) == 1) ? $urandom_range(0, lines - 2) : -1;
      pulse_req();
      send_frame(lines, odd, -1, -1, 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/frame_capture_ctrl.md
FRAME_CAPTURE_CTRL -- requirements
Module: frame_capture_ctrl

Interface
REQ-001 The block SHALL have parameter COL_PIXELS, default 320, pixels per line.
REQ-002 The block SHALL have parameter ROW_PIXELS, default 240, lines per frame.
REQ-003 The block SHALL have parameter NUM_PIXELS, default 76800, pixels per frame (COL_PIXELS*ROW_PIXELS).
REQ-004 The block SHALL have port clk, input, 1, 50 MHz system clock.
REQ-005 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 The block SHALL have port cam_pclk, input, 1, camera pixel clock (asynchronous, ≤ clk/4).
REQ-007 The block SHALL have port cam_vsync, input, 1, camera frame sync; high = vertical blank.
REQ-008 The block SHALL have port cam_href, input, 1, camera line valid.
REQ-009 The block SHALL have port cam_data, input, 8, camera RGB444 byte stream.
REQ-010 The block SHALL have port capture_req, input, 1, single-cycle request to capture one frame.
REQ-011 The block SHALL have port wr_en, output, 1, frame-buffer write strobe.
REQ-012 The block SHALL have port wr_addr, output, 17, frame-buffer write address.
REQ-013 The block SHALL have port wr_data, output, 12, pixel {R[3:0],G[3:0],B[3:0]}.
REQ-014 The block SHALL have port frame_valid, output, 1, buffer holds a complete frame; downstream sender may read.
REQ-015 The block SHALL have port frame_error, output, 1, last capture had wrong line or pixel count.

Function
REQ-016 cam_pclk, cam_vsync, cam_href and cam_data SHALL pass through an identical 2-flop synchroniser; a pclk rise SHALL be detected when synchronised pclk is 1 and its previous value was 0.
REQ-017 All camera sampling SHALL occur only on detected pclk-rise cycles, using the synchronised values.
REQ-018 The FSM SHALL have states IDLE, WAIT_SOF, CAPTURE and DONE.
REQ-019 IDLE -> WAIT_SOF on capture_req; WAIT_SOF -> CAPTURE on a sampled vsync 1->0 transition; CAPTURE -> DONE on a sampled vsync 0->1 transition; DONE -> WAIT_SOF on capture_req.
REQ-020 capture_req in WAIT_SOF or CAPTURE SHALL be ignored.
REQ-021 In CAPTURE, the byte phase SHALL clear on every sampled href 0->1 transition; with href=1, the phase-0 byte supplies R = byte[3:0] and the phase-1 byte supplies G,B = byte[7:0].
REQ-022 wr_en SHALL pulse for exactly 1 clk, in the cycle after the phase-1 byte is sampled, with wr_data = {R, byte1} and wr_addr equal to the current pixel count.
REQ-023 The pixel count SHALL increment after each write and SHALL clear on entry to CAPTURE; writes SHALL be suppressed once the count reaches NUM_PIXELS (no wrap to 0).
REQ-024 A trailing unpaired phase-0 byte at href fall SHALL be discarded.
REQ-025 The line count SHALL increment on each sampled href 1->0 transition in CAPTURE.
REQ-026 On entry to DONE: frame_valid=1; frame_error = (pixel count != NUM_PIXELS) OR (line count != ROW_PIXELS).
REQ-027 frame_valid and frame_error SHALL hold until capture_req is accepted in DONE; frame_valid SHALL clear in the same cycle the FSM leaves DONE.
REQ-028 When vsync rises in the same sample as a completing write, the write SHALL complete before DONE is entered.

Reset
REQ-029 On rst, the FSM SHALL enter IDLE, all counters and the byte phase SHALL clear, synchroniser flops SHALL clear to 0, and wr_en=0, wr_addr=0, wr_data=0, frame_valid=0, frame_error=0.
REQ-030 rst asserted mid-CAPTURE SHALL abort the frame with no further writes; a new capture_req SHALL be required after release.

Structure
REQ-031 Package cam_pkg SHALL hold the FSM state enum, default COL_PIXELS/ROW_PIXELS/NUM_PIXELS, and the 17-bit address typedef.
REQ-032 Sub-module cam_input_sync SHALL implement the synchroniser and pclk-rise detect (REQ-016).

Verification
REQ-033 Reset, then capture_req, then a full 320x240 frame with pixel n bytes {0x0n[3:0], n[7:0]} -> 76800 wr_en pulses, wr_addr 0..76799 in order, frame_valid=1, frame_error=0.
REQ-034 capture_req mid-frame (vsync low) -> the capture starts only at the next vsync fall, and address 0 receives the first pixel of the next frame.
REQ-035 Frame with 239 lines -> 76480 writes, frame_valid=1, frame_error=1.
REQ-036 Line with 641 bytes -> 320 writes for that line, the odd byte is dropped, and the next line starts at the correct address.
REQ-037 Frame with 241 lines -> writes stop at address 76799, none at 76800, frame_error=1.
REQ-038 rst at pixel 1000 -> no wr_en afterwards, all outputs 0; a following capture_req plus frame -> a clean capture from address 0.
